// File: rtl/audio_note_sequencer.sv
// Square-wave note sequencer between game logic and the audio codec FIFOs.
// Mixes a +/-AMP tone into mic pass-through for a fixed number of output samples.
module audio_note_sequencer #(
    parameter int                 HALF_W = 19,
    parameter int                 DUR_W  = 16,
    parameter logic signed [31:0] AMP    = 32'sd10000000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              note_valid,
    output logic              note_ready,
    input  logic [HALF_W-1:0] note_half_period,
    input  logic [DUR_W-1:0]  note_duration,
    input  logic              mute,
    input  logic              audio_in_available,
    input  logic [31:0]       left_channel_audio_in,
    input  logic [31:0]       right_channel_audio_in,
    input  logic              audio_out_allowed,
    output logic              read_audio_in,
    output logic              write_audio_out,
    output logic [31:0]       left_channel_audio_out,
    output logic [31:0]       right_channel_audio_out,
    output logic              note_active,
    output logic              note_done
);

    typedef enum logic [1:0] {
        N_IDLE,
        N_PLAY,
        N_DONE
    } note_state_t;

    typedef enum logic {
        S_WAIT,
        S_HOLD
    } samp_state_t;

    note_state_t       note_q, note_d;
    samp_state_t       samp_q, samp_d;
    logic [HALF_W-1:0] hp_q, hp_d;
    logic [HALF_W-1:0] cnt_q, cnt_d;
    logic [DUR_W-1:0]  rem_q, rem_d;
    logic              snd_q, snd_d;
    logic              ready_q, ready_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [31:0]       left_q, left_d;
    logic [31:0]       right_q, right_d;

    logic              fire;
    logic signed [31:0] tone;

    function automatic logic [31:0] sat32(input logic [31:0] a,
                                          input logic [31:0] b);
        logic [32:0] s;
        s = {a[31], a} + {b[31], b};
        if (s[32] != s[31]) begin
            return s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        return s[31:0];
    endfunction

    always_comb begin
        fire = (samp_q == S_WAIT) & audio_in_available & audio_out_allowed;
        tone = '0;
        if (note_q == N_PLAY && hp_q != '0 && !mute) begin
            tone = snd_q ? AMP : -AMP;
        end
    end

    always_comb begin
        note_d  = note_q;
        samp_d  = samp_q;
        hp_d    = hp_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        snd_d   = snd_q;
        left_d  = left_q;
        right_d = right_q;
        rd_d    = 1'b0;
        wr_d    = 1'b0;

        // Sample handshake: capture, then one quiet cycle for FIFO flags.
        case (samp_q)
            S_WAIT: begin
                if (fire) begin
                    left_d  = sat32(left_channel_audio_in, tone);
                    right_d = sat32(right_channel_audio_in, tone);
                    rd_d    = 1'b1;
                    wr_d    = 1'b1;
                    samp_d  = S_HOLD;
                end
            end
            S_HOLD:  samp_d = S_WAIT;
            default: samp_d = S_WAIT;
        endcase

        if (note_q == N_PLAY && hp_q != '0) begin
            if (cnt_q == hp_q - HALF_W'(1)) begin
                cnt_d = '0;
                snd_d = ~snd_q;
            end else begin
                cnt_d = cnt_q + HALF_W'(1);
            end
        end

        case (note_q)
            N_IDLE: begin
                if (note_valid) begin
                    hp_d   = note_half_period;
                    rem_d  = note_duration;
                    cnt_d  = '0;
                    snd_d  = 1'b0;
                    note_d = (note_duration == '0) ? N_DONE : N_PLAY;
                end
            end
            N_PLAY: begin
                if (fire) begin
                    if (rem_q == DUR_W'(1)) begin
                        note_d = N_DONE;
                    end
                    rem_d = rem_q - DUR_W'(1);
                end
            end
            N_DONE:  note_d = N_IDLE;
            default: note_d = N_IDLE;
        endcase

        ready_d  = (note_d == N_IDLE);
        active_d = (note_d == N_PLAY);
        done_d   = (note_d == N_DONE);
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            note_q   <= N_IDLE;
            samp_q   <= S_WAIT;
            hp_q     <= '0;
            cnt_q    <= '0;
            rem_q    <= '0;
            snd_q    <= 1'b0;
            ready_q  <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            left_q   <= '0;
            right_q  <= '0;
        end else begin
            note_q   <= note_d;
            samp_q   <= samp_d;
            hp_q     <= hp_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            snd_q    <= snd_d;
            ready_q  <= ready_d;
            active_q <= active_d;
            done_q   <= done_d;
            rd_q     <= rd_d;
            wr_q     <= wr_d;
            left_q   <= left_d;
            right_q  <= right_d;
        end
    end

    assign note_ready              = ready_q;
    assign note_active             = active_q;
    assign note_done               = done_q;
    assign read_audio_in           = rd_q;
    assign write_audio_out         = wr_q;
    assign left_channel_audio_out  = left_q;
    assign right_channel_audio_out = right_q;

endmodule

// File: tb/tb_audio_note_sequencer.sv
// Randomized scoreboard bench for audio_note_sequencer.
// Reference model works from note start time and sample counts.
module tb_audio_note_sequencer;

    localparam longint AMP = 10000000;

    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        note_valid = 1'b0;
    logic        note_ready;
    logic [18:0] note_half_period = '0;
    logic [15:0] note_duration = '0;
    logic        mute = 1'b0;
    logic        audio_in_available = 1'b0;
    logic [31:0] left_channel_audio_in = '0;
    logic [31:0] right_channel_audio_in = '0;
    logic        audio_out_allowed = 1'b0;
    logic        read_audio_in;
    logic        write_audio_out;
    logic [31:0] left_channel_audio_out;
    logic [31:0] right_channel_audio_out;
    logic        note_active;
    logic        note_done;

    audio_note_sequencer dut (
        .CLOCK_50               (CLOCK_50),
        .reset                  (reset),
        .note_valid             (note_valid),
        .note_ready             (note_ready),
        .note_half_period       (note_half_period),
        .note_duration          (note_duration),
        .mute                   (mute),
        .audio_in_available     (audio_in_available),
        .left_channel_audio_in  (left_channel_audio_in),
        .right_channel_audio_in (right_channel_audio_in),
        .audio_out_allowed      (audio_out_allowed),
        .read_audio_in          (read_audio_in),
        .write_audio_out        (write_audio_out),
        .left_channel_audio_out (left_channel_audio_out),
        .right_channel_audio_out(right_channel_audio_out),
        .note_active            (note_active),
        .note_done              (note_done)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] l;
        logic [31:0] r;
    } samp_t;
    samp_t expq[$];

    // Model: phase 0 idle, 1 playing, 2 done pulse.
    int m_phase = 0;
    int m_k = 0;
    int m_left = 0;
    int m_hp = 0;
    bit m_hold = 0;
    bit mon_en = 0;

    function automatic logic [31:0] sat(input logic [31:0] a, input longint t);
        longint s;
        logic [63:0] v;
        s = longint'($signed(a)) + t;
        if (s > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        v = s;
        return v[31:0];
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge CLOCK_50);
        if (reset) begin
            m_phase = 0;
            m_hold  = 0;
            m_k     = 0;
            expq.delete();
        end else begin : step
            bit     cap;
            longint tone;
            samp_t  s;
            cap  = !m_hold && audio_in_available && audio_out_allowed;
            tone = 0;
            if (m_phase == 1) begin
                m_k++;
                if (m_hp != 0 && !mute)
                    tone = ((((m_k - 1) / m_hp) % 2) == 1) ? AMP : -AMP;
            end
            if (cap) begin
                s.l = sat(left_channel_audio_in, tone);
                s.r = sat(right_channel_audio_in, tone);
                expq.push_back(s);
            end
            m_hold = cap;
            if (m_phase == 0) begin
                if (note_valid) begin
                    m_hp    = int'(note_half_period);
                    m_left  = int'(note_duration);
                    m_k     = 0;
                    m_phase = (note_duration == 0) ? 2 : 1;
                end
            end else if (m_phase == 1) begin
                if (cap) begin
                    if (m_left == 1) m_phase = 2;
                    else m_left--;
                end
            end else begin
                m_phase = 0;
            end
        end
    end

    initial forever begin
        @(negedge CLOCK_50);
        if (mon_en) begin
            check("note_ready", note_ready, m_phase == 0);
            check("note_active", note_active, m_phase == 1);
            check("note_done", note_done, m_phase == 2);
            check("read_eq_write", read_audio_in, write_audio_out);
            if (write_audio_out) begin
                if (expq.size() == 0) begin
                    check("unexpected_write", 1, 0);
                end else begin : pop
                    samp_t s;
                    s = expq.pop_front();
                    check("left_out", left_channel_audio_out, s.l);
                    check("right_out", right_channel_audio_out, s.r);
                end
            end
        end
    end

    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 3000 && m_phase != 0; i++) tick();
        check("idle_timeout", m_phase, 0);
    endtask

    task automatic send_note(input int h, input int d);
        wait_idle();
        note_valid       = 1'b1;
        note_half_period = 19'(h);
        note_duration    = 16'(d);
        tick();
        note_valid       = 1'b0;
        note_half_period = 19'($urandom);
        note_duration    = 16'($urandom);
    endtask

    function automatic logic [31:0] rnd_sample();
        case ($urandom_range(0, 3))
            0:       return 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
            1:       return 32'h8000_0000 + 32'($urandom_range(0, 255));
            2:       return 32'($signed($urandom_range(0, 2000)) - 1000);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge CLOCK_50);
        #1;
        mon_en = 1;
        check("rst_left", left_channel_audio_out, 0);
        check("rst_right", right_channel_audio_out, 0);
        reset = 1'b0;

        left_channel_audio_in  = 32'd100;
        right_channel_audio_in = -32'sd5;
        audio_in_available     = 1'b1;
        audio_out_allowed      = 1'b1;
        repeat (10) tick();

        left_channel_audio_in  = '0;
        right_channel_audio_in = '0;
        send_note(4, 3);
        wait_idle();

        left_channel_audio_in  = 32'h7FFF_FF00;
        right_channel_audio_in = 32'h8000_0010;
        send_note(3, 8);
        wait_idle();

        left_channel_audio_in  = 32'd5;
        right_channel_audio_in = -32'sd7;
        send_note(9, 0);
        send_note(0, 2);
        wait_idle();

        send_note(3, 4);
        repeat (3) tick();
        audio_out_allowed = 1'b0;
        repeat (50) tick();
        check("bp_holds_note", m_phase, 1);
        audio_out_allowed = 1'b1;
        wait_idle();

        for (int c = 0; c < 3000; c++) begin
            note_valid = ($urandom_range(0, 3) == 0);
            note_half_period = ($urandom_range(0, 15) == 0) ?
                19'($urandom_range(100, 1000)) : 19'($urandom_range(0, 7));
            note_duration          = 16'($urandom_range(0, 5));
            mute                   = ($urandom_range(0, 7) == 0);
            audio_in_available     = ($urandom_range(0, 3) != 0);
            audio_out_allowed      = ($urandom_range(0, 3) != 0);
            left_channel_audio_in  = rnd_sample();
            right_channel_audio_in = rnd_sample();
            tick();
        end
        note_valid         = 1'b0;
        mute               = 1'b0;
        audio_in_available = 1'b1;
        audio_out_allowed  = 1'b1;
        wait_idle();

        send_note(5, 8);
        for (int i = 0; i < 100 && m_left != 5; i++) tick();
        check("reach_rem5", m_left, 5);
        reset = 1'b1;
        tick();
        check("mid_rst_ready", note_ready, 1);
        check("mid_rst_active", note_active, 0);
        check("mid_rst_done", note_done, 0);
        check("mid_rst_wr", write_audio_out, 0);
        check("mid_rst_rd", read_audio_in, 0);
        check("mid_rst_left", left_channel_audio_out, 0);
        check("mid_rst_right", right_channel_audio_out, 0);
        reset = 1'b0;
        repeat (6) tick();
        check("queue_drained", expq.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
